// File: rtl/fire_pkg.sv
// Shared sizes, word type and writer FSM states for the fire6 squeeze output-map writer.
package fire_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CH     = 64;
  localparam int unsigned WOUT   = 16;
  localparam int unsigned NPIX   = WOUT * WOUT;
  localparam int unsigned ADDR_W = $clog2(NPIX * CH);
  localparam int unsigned CH_W   = $clog2(CH);
  // One spare bit so the pixel counter can hold NPIX itself without wrapping.
  localparam int unsigned PIX_W  = $clog2(NPIX) + 1;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/fire_ofm_ram.sv
// Simple dual-port feature-map RAM: one write port, one registered read-first read port.
module fire_ofm_ram
  import fire_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  word_t mem_q [2**AddrW];
  word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fire6_squeeze_ofm_writer.sv
// Captures squeeze-layer channel vectors, serialises them pixel-major into the feature-map
// RAM one word per cycle, and signals the squeeze layer once every pixel is stored.
module fire6_squeeze_ofm_writer
  import fire_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_i,
  input  logic [WIDTH-1:0]  ofm_i [CH],
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              ram_feedback,
  output logic              layer_done_o,
  output logic              overrun_o
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              feedback_q, feedback_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              rd_valid_q;
  logic              rd_seen_q;
  logic              load_shadow;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  ram_rdata;
  word_t             shadow_q [CH];

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pix_d       = pix_q;
    load_shadow = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sample_i) begin
          load_shadow = 1'b1;
          ch_d        = '0;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        ch_d = ch_q + 1'b1;
        if (ch_q == CH_W'(CH - 1)) begin
          ch_d    = '0;
          pix_d   = pix_q + 1'b1;
          state_d = (pix_q == PIX_W'(NPIX - 1)) ? StDone : StIdle;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Any sample not accepted in IDLE is dropped, including one in the final drain cycle.
  assign ovr_d      = ovr_q | (sample_i & (state_q != StIdle));
  assign feedback_d = (state_d == StDone) && (state_q != StDone);
  assign done_d     = done_q | feedback_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      pix_q      <= '0;
      feedback_q <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pix_q      <= pix_d;
      feedback_q <= feedback_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      rd_valid_q <= rd_en_i;
      rd_seen_q  <= rd_seen_q | rd_en_i;
    end
  end

  always_ff @(posedge clk) begin
    if (load_shadow) begin
      shadow_q <= ofm_i;
    end
  end

  assign wr_en   = (state_q == StDrain);
  assign wr_addr = ADDR_W'(pix_q) * ADDR_W'(CH) + ADDR_W'(ch_q);

  fire_ofm_ram #(
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (shadow_q[ch_q]),
    .re_i    (rd_en_i),
    .raddr_i (rd_addr_i),
    .rdata_o (ram_rdata)
  );

  // The RAM output register has no reset; mask it until a read completes after reset.
  assign rd_data_o    = rd_seen_q ? ram_rdata : '0;
  assign rd_valid_o   = rd_valid_q;
  assign ram_feedback = feedback_q;
  assign layer_done_o = done_q;
  assign overrun_o    = ovr_q;

endmodule
